// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 3x3 streaming convolution engine.
package conv_pkg;

  localparam int COEF_N      = 9;
  localparam int COEF_CENTER = 4;
  localparam int COEF_IDX_W  = 4;

  // Index 0 is top-left, row-major; only the centre tap is set.
  localparam int KERNEL_IDENTITY [COEF_N] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

  function automatic int acc_width(input int pxl_w, input int coef_w);
    return pxl_w + coef_w + 5;
  endfunction

  // Clamp a signed value to the unsigned range 0 .. 2^w-1.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (v < 64'sd0) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: single address, write-on-enable, combinational read.
module line_buffer #(
  parameter int DEPTH = 220,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: line buffers + window, products, adder tree, shift/saturate.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W  = 220,
  parameter int IMG_H  = 220,
  parameter int PXL_W  = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = acc_width(PXL_W, COEF_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PXL_W-1:0]         pxl_in,
  input  logic                     pxl_in_valid,
  input  logic                     sof,
  input  logic                     coef_we,
  input  logic [COEF_IDX_W-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic [3:0]               shift,
  output logic [PXL_W-1:0]         pxl_out,
  output logic signed [ACC_W-1:0]  sum_out,
  output logic                     pxl_out_valid,
  output logic                     frame_done
);

  localparam int PROD_W = PXL_W + COEF_W + 1;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic          at_origin, at_last, win_full;

  logic signed [COEF_W-1:0] coef_sh  [COEF_N];
  logic signed [COEF_W-1:0] coef_act [COEF_N];

  logic [PXL_W-1:0] lb1_q, lb2_q;

  logic [PXL_W-1:0]         win_p0 [3][3];
  logic [3:0]               shift_p0, shift_p1, shift_p2;
  logic                     vld_p0, vld_p1, vld_p2;
  logic                     fd_p0, fd_p1, fd_p2;
  logic signed [PROD_W-1:0] prod_c  [COEF_N];
  logic signed [PROD_W-1:0] prod_p1 [COEF_N];
  logic signed [ACC_W-1:0]  sum_c, sum_p2, shifted_c;
  logic [PXL_W-1:0]         pxl_sat_c;

  // sof forces the accepted pixel to (0,0) regardless of where the counters are
  assign eff_col   = sof ? '0 : col;
  assign eff_row   = sof ? '0 : row;
  assign at_origin = (eff_col == '0) && (eff_row == '0);
  assign at_last   = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
  assign win_full  = (eff_col >= COL_MIN) && (eff_row >= ROW_MIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (pxl_in_valid) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end
  end

  // Commit reads the shadow bank before any same-edge write lands in it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < COEF_N; k++) begin
        coef_sh[k]  <= COEF_W'(KERNEL_IDENTITY[k]);
        coef_act[k] <= COEF_W'(KERNEL_IDENTITY[k]);
      end
    end else begin
      if (pxl_in_valid && at_origin) coef_act <= coef_sh;
      if (coef_we && (coef_addr < COEF_IDX_W'(COEF_N))) coef_sh[coef_addr] <= coef_data;
    end
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PXL_W)) u_lb1 (
    .clk  (clk),
    .en   (pxl_in_valid),
    .addr (eff_col),
    .din  (pxl_in),
    .dout (lb1_q)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PXL_W)) u_lb2 (
    .clk  (clk),
    .en   (pxl_in_valid),
    .addr (eff_col),
    .din  (lb1_q),
    .dout (lb2_q)
  );

  // ---- stage p0: window shift (row 0 = oldest line, column 2 = newest pixel)
  always_ff @(posedge clk) begin
    if (pxl_in_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_p0[i][0] <= win_p0[i][1];
        win_p0[i][1] <= win_p0[i][2];
      end
      win_p0[0][2] <= lb2_q;
      win_p0[1][2] <= lb1_q;
      win_p0[2][2] <= pxl_in;
      shift_p0     <= shift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      fd_p0  <= 1'b0;
    end else begin
      vld_p0 <= pxl_in_valid && win_full;
      fd_p0  <= pxl_in_valid && at_last;
    end
  end

  // ---- stage p1: unsigned pixel x signed coefficient
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_c[3*i+j] = $signed(PROD_W'(win_p0[i][j])) * PROD_W'(coef_act[3*i+j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    prod_p1  <= prod_c;
    shift_p1 <= shift_p0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      fd_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      fd_p1  <= fd_p0;
    end
  end

  // ---- stage p2: adder tree (ACC_W holds nine worst-case products)
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < COEF_N; k++) begin
      sum_c = sum_c + ACC_W'(prod_p1[k]);
    end
  end

  always_ff @(posedge clk) begin
    sum_p2   <= sum_c;
    shift_p2 <= shift_p1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      fd_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      fd_p2  <= fd_p1;
    end
  end

  // ---- output stage: arithmetic shift then clamp to pixel range
  assign shifted_c = sum_p2 >>> shift_p2;
  assign pxl_sat_c = PXL_W'(saturate(64'(shifted_c), unsigned'(PXL_W)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out       <= '0;
      sum_out       <= '0;
      pxl_out_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      pxl_out       <= pxl_sat_c;
      sum_out       <= sum_p2;
      pxl_out_valid <= vld_p2;
      frame_done    <= fd_p2 && vld_p2;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on an 8x6 image: frame-level reference model plus literal checks.
module tb_conv3x3_stream;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int CF = 8;
  localparam int AW = PW + CF + 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [PW-1:0]        pxl_in = '0;
  logic                 pxl_in_valid = 1'b0;
  logic                 sof = 1'b0;
  logic                 coef_we = 1'b0;
  logic [3:0]           coef_addr = '0;
  logic signed [CF-1:0] coef_data = '0;
  logic [3:0]           shift = '0;
  logic [PW-1:0]        pxl_out;
  logic signed [AW-1:0] sum_out;
  logic                 pxl_out_valid;
  logic                 frame_done;

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .PXL_W(PW), .COEF_W(CF)) dut (
    .clk           (clk),
    .reset         (reset),
    .pxl_in        (pxl_in),
    .pxl_in_valid  (pxl_in_valid),
    .sof           (sof),
    .coef_we       (coef_we),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .shift         (shift),
    .pxl_out       (pxl_out),
    .sum_out       (sum_out),
    .pxl_out_valid (pxl_out_valid),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int px; int sum; bit fd; } exp_t;

  exp_t exp_q[$];
  int   img [H][W];
  int   k_sh [9];
  int   k_act [9];
  int   mr, mc, cur_shift;
  int   cyc = 0;
  int   total = 0, bad = 0;
  int   out_cnt = 0, fd_cnt = 0, last_px = 0, last_sum = 0, fd_sum = 0;
  int   obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected outputs fall due 3 edges after the accepting edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("out_valid", int'(pxl_out_valid), 1);
        check("pxl_out", int'(pxl_out), e.px);
        check("sum_out", int'(sum_out), e.sum);
        check("frame_done", int'(frame_done), int'(e.fd));
        if (pxl_out_valid) begin
          out_cnt++;
          last_px  = int'(pxl_out);
          last_sum = int'(sum_out);
          obs_q.push_back(int'(pxl_out));
          if (frame_done) begin
            fd_cnt++;
            fd_sum = int'(sum_out);
          end
        end
      end else begin
        check("idle_valid", int'(pxl_out_valid), 0);
        check("idle_frame_done", int'(frame_done), 0);
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      k_sh[k]  = (k == 4) ? 1 : 0;
      k_act[k] = k_sh[k];
    end
    mr = 0;
    mc = 0;
    exp_q.delete();
  endtask

  task automatic step(input bit v, input int p, input bit s,
                      input bit we, input int addr, input int data);
    int r, c, sum, px;
    @(negedge clk);
    #1;
    pxl_in_valid = v;
    pxl_in       = PW'(p);
    sof          = s;
    coef_we      = we;
    coef_addr    = 4'(addr);
    coef_data    = CF'(data);
    shift        = 4'(cur_shift);
    if (v) begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      if (r == 0 && c == 0) k_act = k_sh;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        sum = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            sum += img[r-2+i][c-2+j] * k_act[3*i+j];
        px = sum >>> cur_shift;
        if (px < 0) px = 0;
        if (px > 255) px = 255;
        exp_q.push_back('{cyc + 4, px, sum, (r == H-1 && c == W-1)});
      end
      mc = (c == W-1) ? 0 : c + 1;
      mr = (c == W-1) ? ((r == H-1) ? 0 : r + 1) : r;
    end
    if (we && addr < 9) k_sh[addr] = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic write_kernel(input int v, input int centre);
    for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b0, 1'b1, i, (i == 4) ? centre : v);
  endtask

  task automatic stream_frame(input bit ramp, input int cval, input bit with_sof, input int gap_pct);
    for (int n = 0; n < H*W; n++) begin
      if ($urandom_range(0, 99) < gap_pct) step(1'b0, 0, 1'b0, 1'b0, 0, 0);
      step(1'b1, ramp ? 8*(n/W) + (n%W) : cval, with_sof && n == 0, 1'b0, 0, 0);
    end
  endtask

  initial begin
    int o0, f0, k;
    model_reset();
    cur_shift = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_pxl_out", int'(pxl_out), 0);
    check("rst_sum_out", int'(sum_out), 0);
    check("rst_valid", int'(pxl_out_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // identity kernel, ramp image, no sof on the first frame
    obs_q.delete();
    o0 = out_cnt; f0 = fd_cnt;
    stream_frame(1'b1, 0, 1'b0, 0);
    idle(5);
    check("id_count", out_cnt - o0, 24);
    check("id_first", obs_q.size() > 0 ? obs_q[0] : -1, 9);
    check("id_last", last_px, 38);   // centre of the last window is p(4,6)
    check("id_frame_done", fd_cnt - f0, 1);

    // all-ones kernel on constant 200
    write_kernel(1, 1);
    stream_frame(1'b0, 200, 1'b1, 0);
    idle(5);
    check("sat_sum", last_sum, 1800);
    check("sat_pxl", last_px, 255);
    cur_shift = 3;
    stream_frame(1'b0, 200, 1'b1, 0);
    idle(5);
    check("shift3_pxl", last_px, 225);
    cur_shift = 0;

    // negative clamp and Laplacian on constant 100
    write_kernel(-1, -1);
    stream_frame(1'b0, 100, 1'b1, 0);
    idle(5);
    check("neg_sum", last_sum, -900);
    check("neg_pxl", last_px, 0);
    write_kernel(-1, 8);
    stream_frame(1'b0, 100, 1'b1, 0);
    idle(5);
    check("lap_sum", last_sum, 0);
    check("lap_pxl", last_px, 0);

    // identity with ~30% input bubbles
    write_kernel(0, 1);
    obs_q.delete();
    o0 = out_cnt;
    stream_frame(1'b1, 0, 1'b1, 30);
    idle(5);
    check("gap_count", out_cnt - o0, 24);
    k = 0;
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        check("gap_value", (k < obs_q.size()) ? obs_q[k] : -1, 8*(r-1) + (c-1));
        k++;
      end
    end

    // mid-frame ones write only takes effect next frame; same-edge write at (0,0) is not committed
    for (int n = 0; n < H*W; n++)
      step(1'b1, 8*(n/W) + (n%W), n == 0, (n >= 10 && n < 19), n - 10, 1);
    idle(5);
    check("commit_f1", fd_sum, 38);
    for (int n = 0; n < H*W; n++)
      step(1'b1, 8*(n/W) + (n%W), 1'b0, n == 0, 4, 2);
    idle(5);
    check("commit_f2", fd_sum, 342);

    // sof at (3,4) aborts the frame
    o0 = out_cnt; f0 = fd_cnt;
    for (int n = 0; n < 3*W + 4; n++)
      step(1'b1, 8*(n/W) + (n%W), 1'b0, 1'b0, 0, 0);
    stream_frame(1'b1, 0, 1'b1, 0);
    idle(5);
    check("resync_count", out_cnt - o0, 32);
    check("resync_frame_done", fd_cnt - f0, 1);
    check("resync_sum", fd_sum, 380);

    // reset while pixel (4,1) is presented
    write_kernel(1, 1);
    for (int n = 0; n < 4*W + 1; n++)
      step(1'b1, 8*(n/W) + (n%W), n == 0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    pxl_in = PW'(33);
    reset  = 1'b0;
    model_reset();
    #1;
    check("midrst_valid", int'(pxl_out_valid), 0);
    check("midrst_pxl", int'(pxl_out), 0);
    check("midrst_sum", int'(sum_out), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    idle(2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    o0 = out_cnt; f0 = fd_cnt;
    stream_frame(1'b1, 0, 1'b0, 0);
    idle(6);
    check("post_rst_count", out_cnt - o0, 24);
    check("post_rst_frame_done", fd_cnt - f0, 1);
    check("post_rst_sum", fd_sum, 38);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
